uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Receive-side controller between the UART receiver datapath and the APB register block. It captures each byte the receiver delivers on its one-cycle valid pulse into a first-word-fall-through FIFO and presents bytes to the register block over a valid/ready read port. It also tracks overrun and raises threshold and character-timeout interrupts.

Parameters:
FifoDepth, 8, number of byte entries; power of two, minimum 2
TimeoutCycles, 640, consecutive idle clk cycles with FIFO non-empty before timeout fires (640 = 4 chars x 10 bits x 16 ticks); minimum 1
CntW, $clog2(FifoDepth)+1, derived width of the count and threshold fields; not overridable

Ports:
clk_i  in  1  sole clock
rst_i  in  1  synchronous active-high reset
en_i  in  1  receive enable; when low, incoming bytes are ignored (not pushed, no overrun)
flush_i  in  1  single-cycle FIFO flush request
rx_data_i  in  8  byte from receiver
rx_valid_i  in  1  one-cycle pulse, rx_data_i valid
rd_data_o  out  8  FIFO head byte
rd_valid_o  out  1  FIFO non-empty
rd_ready_i  in  1  consumer pop; a pop occurs on a cycle where rd_valid_o && rd_ready_i
count_o  out  CntW  current occupancy, 0..FifoDepth
full_o  out  1  count_o == FifoDepth
empty_o  out  1  count_o == 0
threshold_i  in  CntW  interrupt threshold level
irq_threshold_o  out  1  level interrupt, count at or above threshold
irq_timeout_o  out  1  level interrupt, character timeout
overrun_o  out  1  sticky overrun flag
overrun_clr_i  in  1  clears overrun_o

Behaviour:
- Clock and reset:
  - Single clock clk_i. Reset rst_i is synchronous, active-high, and sampled only on the clk_i rising edge.
  - On reset: FIFO empty, pointers 0, count_o=0, empty_o=1, full_o=0, rd_valid_o=0, overrun_o=0, irq_timeout_o=0, irq_threshold_o=0, timeout FSM in T_IDLE.
  - rd_data_o is don't-care while rd_valid_o=0; it resets to 0.
  - Reset asserted mid-operation discards all contents on the next edge. It has priority over every other input.
- Storage:
  - Circular buffer with write/read pointers of log2(FifoDepth) bits; pointers wrap naturally.
  - count_o is a registered CntW-bit counter.
- Push condition: rx_valid_i && en_i && !flush_i && (!full_o || pop).
  - A push at full with a simultaneous pop is accepted; count is unchanged.
- Pop: rd_valid_o && rd_ready_i && !flush_i. rd_ready_i while empty has no effect.
- Latency: a byte pushed at edge N is visible on rd_data_o/rd_valid_o after edge N; rd_data_o always equals the head entry.
- Simultaneous push and pop when not full: both pointers advance and count is unchanged. Push into an empty FIFO with rd_ready_i high does not pop in the same cycle.
- Overrun:
  - Set when rx_valid_i && en_i && !flush_i && full_o && !pop. The incoming byte is dropped and FIFO contents are untouched.
  - Cleared by overrun_clr_i. If set and clear occur in the same cycle, set wins.
- Flush: on a cycle with flush_i=1, pointers and count go to 0 and the timeout FSM goes to T_IDLE.
  - A push or pop in the flush cycle is ignored.
  - A byte arriving in the flush cycle is dropped and does not set overrun.
  - overrun_o is unaffected by flush.
- irq_threshold_o: combinational (threshold_i != 0) && (count_o >= threshold_i).
- Timeout FSM:
  - States:
    - T_IDLE: FIFO empty or just reset.
    - T_COUNT: counter running.
    - T_FIRED: irq_timeout_o=1.
  - Activity is a push, pop, or flush in the current cycle.
  - Counter width $clog2(TimeoutCycles+1); it resets to 0 on any activity.
  - T_IDLE -> T_COUNT on the edge where count becomes non-zero; counter cleared.
  - T_COUNT: counter increments each cycle without activity.
    - When it reaches TimeoutCycles, move to T_FIRED.
    - On activity with a non-empty result, stay in T_COUNT and clear the counter.
    - If the result is empty, go to T_IDLE.
  - T_FIRED: irq_timeout_o=1 (registered, equal to state==T_FIRED).
    - Any pop, push or flush leaves T_FIRED: to T_COUNT with the counter cleared if the FIFO remains non-empty, else to T_IDLE.
  - en_i=0 does not stop the counter.

Test Plan:
- Reset, then 3 rx_valid_i pulses with 0x11, 0x22, 0x33 and rd_ready_i=0 -> count_o=3, rd_data_o=0x11; popping 3 times yields 0x11, 0x22, 0x33 in order, then empty_o=1.
- Fill 8 bytes 0x00..0x07, then push 0xAA -> full_o=1, overrun_o=1, contents unchanged. Next, push 0xBB with a simultaneous pop -> accepted, count stays 8, last entry is 0xBB. overrun_clr_i with a simultaneous overrunning push -> overrun_o remains 1.
- threshold_i=4: push 3 bytes -> irq_threshold_o=0; 4th push -> 1 after that edge; one pop -> 0. threshold_i=0 -> always 0.
- TimeoutCycles=640: push 1 byte, then idle -> irq_timeout_o rises exactly 640 cycles after the push edge. A push at cycle 639 restarts the count. A pop that empties the FIFO while fired -> irq_timeout_o=0 and FSM in T_IDLE.
- 5 bytes stored, then flush_i together with rx_valid_i=1 (0x55) -> count_o=0 next cycle, 0x55 not stored, overrun_o unchanged.
- en_i=0 with 10 rx_valid_i pulses -> count stays 0, overrun_o=0. rst_i asserted with 6 bytes stored and timeout fired -> all outputs at reset values after one edge.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: byte FIFO (first-word-fall-through) with
// valid/ready read port, sticky overrun, threshold and character-timeout IRQs.
module uart_rx_ctrl #(
  parameter  int FifoDepth     = 8,
  parameter  int TimeoutCycles = 640,
  localparam int CntW          = $clog2(FifoDepth) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            flush_i,
  input  logic [7:0]      rx_data_i,
  input  logic            rx_valid_i,
  output logic [7:0]      rd_data_o,
  output logic            rd_valid_o,
  input  logic            rd_ready_i,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o,
  input  logic [CntW-1:0] threshold_i,
  output logic            irq_threshold_o,
  output logic            irq_timeout_o,
  output logic            overrun_o,
  input  logic            overrun_clr_i
);

  localparam int AW = $clog2(FifoDepth);
  localparam int TW = $clog2(TimeoutCycles + 1);

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_COUNT = 2'd1,
    T_FIRED = 2'd2
  } t_state_e;

  logic [7:0]      mem_q [FifoDepth];
  logic [7:0]      mem_d [FifoDepth];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            ovr_q, ovr_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  t_state_e        state_q, state_d;

  logic push_s, pop_s, ovr_set_s, activity_s;

  // Push/pop qualification; a pop at full frees the slot for a same-cycle push.
  always_comb begin
    pop_s      = !empty_q && rd_ready_i && !flush_i;
    push_s     = rx_valid_i && en_i && !flush_i && (!full_q || pop_s);
    ovr_set_s  = rx_valid_i && en_i && !flush_i && full_q && !pop_s;
    activity_s = push_s || pop_s || flush_i;
  end

  // Next-state of storage, pointers, occupancy and overrun flag.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = rx_data_i;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == CntW'(FifoDepth));
    empty_d = (count_d == CntW'(0));
    if (ovr_set_s) begin
      ovr_d = 1'b1;
    end else if (overrun_clr_i) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // FIFO storage and status registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FifoDepth; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovr_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovr_q    <= ovr_d;
    end
  end

  // Timeout FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= T_IDLE;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Timeout FSM next state; the counter holds idle cycles since the last activity.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      T_IDLE: begin
        tcnt_d = '0;
        if (count_d != CntW'(0)) begin
          state_d = T_COUNT;
        end else begin
          state_d = T_IDLE;
        end
      end
      T_COUNT: begin
        if (activity_s) begin
          tcnt_d  = '0;
          state_d = (count_d != CntW'(0)) ? T_COUNT : T_IDLE;
        end else if (tcnt_q == TW'(TimeoutCycles - 1)) begin
          tcnt_d  = tcnt_q + TW'(1);
          state_d = T_FIRED;
        end else begin
          tcnt_d  = tcnt_q + TW'(1);
          state_d = T_COUNT;
        end
      end
      T_FIRED: begin
        if (activity_s) begin
          tcnt_d  = '0;
          state_d = (count_d != CntW'(0)) ? T_COUNT : T_IDLE;
        end else begin
          tcnt_d  = tcnt_q;
          state_d = T_FIRED;
        end
      end
      default: begin
        tcnt_d  = '0;
        state_d = T_IDLE;
      end
    endcase
  end

  // Output decode from registered state.
  always_comb begin
    rd_data_o       = mem_q[rd_ptr_q];
    rd_valid_o      = !empty_q;
    count_o         = count_q;
    full_o          = full_q;
    empty_o         = empty_q;
    overrun_o       = ovr_q;
    irq_timeout_o   = (state_q == T_FIRED);
    irq_threshold_o = (threshold_i != CntW'(0)) && (count_q >= threshold_i);
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized + directed bench for uart_rx_ctrl: queue-based reference model
// updated on each clock edge, monitor compares every cycle on the falling edge.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 8;
  localparam int TO    = 640;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          en_i = 1'b1;
  logic          flush_i = 1'b0;
  logic [7:0]    rx_data_i = 8'h00;
  logic          rx_valid_i = 1'b0;
  logic [7:0]    rd_data_o;
  logic          rd_valid_o;
  logic          rd_ready_i = 1'b0;
  logic [CW-1:0] count_o;
  logic          full_o, empty_o;
  logic [CW-1:0] threshold_i = '0;
  logic          irq_threshold_o, irq_timeout_o, overrun_o;
  logic          overrun_clr_i = 1'b0;

  uart_rx_ctrl #(.FifoDepth(DEPTH), .TimeoutCycles(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .flush_i(flush_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
    .threshold_i(threshold_i), .irq_threshold_o(irq_threshold_o),
    .irq_timeout_o(irq_timeout_o), .overrun_o(overrun_o),
    .overrun_clr_i(overrun_clr_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: occupancy, sticky overrun, idle cycles since activity.
  int       m_cnt = 0;
  bit       m_ovr = 1'b0;
  int       m_idle = 0;
  logic [7:0] sb_q[$];

  wire m_pop  = (m_cnt != 0) && rd_ready_i && !flush_i;
  wire m_push = rx_valid_i && en_i && !flush_i && ((m_cnt < DEPTH) || m_pop);
  wire m_oset = rx_valid_i && en_i && !flush_i && (m_cnt == DEPTH) && !m_pop;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_cnt  <= 0;
      m_ovr  <= 1'b0;
      m_idle <= 0;
      sb_q.delete();
    end else begin
      if (flush_i) begin
        m_cnt <= 0;
        sb_q.delete();
      end else begin
        m_cnt <= m_cnt + int'(m_push) - int'(m_pop);
        if (m_push) sb_q.push_back(rx_data_i);
      end
      if (m_oset) m_ovr <= 1'b1;
      else if (overrun_clr_i) m_ovr <= 1'b0;
      if (m_push || m_pop || flush_i) m_idle <= 0;
      else if (m_idle < 100000) m_idle <= m_idle + 1;
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("count", int'(count_o), m_cnt);
      chk("full", int'(full_o), int'(m_cnt == DEPTH));
      chk("empty", int'(empty_o), int'(m_cnt == 0));
      chk("rd_valid", int'(rd_valid_o), int'(m_cnt != 0));
      chk("overrun", int'(overrun_o), int'(m_ovr));
      chk("irq_threshold", int'(irq_threshold_o),
          int'((threshold_i != 0) && (m_cnt >= int'(threshold_i))));
      chk("irq_timeout", int'(irq_timeout_o), int'((m_cnt != 0) && (m_idle >= TO)));
      if (!rst_i && rd_valid_o && rd_ready_i && !flush_i) begin
        if (sb_q.size() == 0) begin
          chk("pop_nonempty", 1, 0);
        end else begin
          chk("rd_data", int'(rd_data_o), int'(sb_q.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    rx_valid_i    = 1'b0;
    flush_i       = 1'b0;
    overrun_clr_i = 1'b0;
    rd_ready_i    = 1'b0;
    rst_i         = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    tick();
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      rd_ready_i = 1'b1;
      tick();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    chk("rd_data_reset", int'(rd_data_o), 0);
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    idle(1);

    // In-order delivery.
    push(8'h11); push(8'h22); push(8'h33);
    idle(2);
    pop_n(3);
    idle(1);

    // Full, overrun, push-with-pop at full, set beats clear.
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    push(8'hAA);
    rx_valid_i = 1'b1; rx_data_i = 8'hBB; rd_ready_i = 1'b1; tick();
    rx_valid_i = 1'b1; rx_data_i = 8'hCC; overrun_clr_i = 1'b1; tick();
    overrun_clr_i = 1'b1; tick();
    pop_n(DEPTH);
    idle(1);

    // Threshold interrupt.
    threshold_i = CW'(4);
    push(8'h01); push(8'h02); push(8'h03);
    push(8'h04);
    pop_n(1);
    threshold_i = CW'(0);
    idle(2);
    pop_n(3);

    // Character timeout: exact firing, restart, pop while fired.
    push(8'h5A);
    idle(TO + 3);
    pop_n(1);
    push(8'h61);
    idle(TO - 2);
    push(8'h62);
    idle(TO + 2);
    pop_n(2);
    idle(2);

    // Flush with a concurrent byte.
    for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
    rx_valid_i = 1'b1; rx_data_i = 8'h55; flush_i = 1'b1; tick();
    idle(2);

    // Receive disabled.
    en_i = 1'b0;
    for (int i = 0; i < 10; i++) push(8'h70 + 8'(i));
    en_i = 1'b1;
    idle(1);

    // Reset while full-ish and timed out.
    for (int i = 0; i < 6; i++) push(8'h80 + 8'(i));
    idle(TO + 5);
    do_reset();
    idle(2);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      rx_valid_i    = ($urandom_range(0, 99) < 50);
      rx_data_i     = 8'($urandom);
      en_i          = ($urandom_range(0, 99) < 90);
      rd_ready_i    = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 30 : 70));
      flush_i       = ($urandom_range(0, 99) < 2);
      overrun_clr_i = ($urandom_range(0, 99) < 5);
      threshold_i   = CW'($urandom_range(0, DEPTH));
      rst_i         = ($urandom_range(0, 999) < 3);
      tick();
    end
    en_i = 1'b1;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
